// File: rtl/frame_reg_sync_if.sv
// frame_reg_sync_if
//   Processor-side write port of the position-register scheduler.
//   master modport: the game processor (drives requests, sees wr_ready).
//   slave  modport: frame_reg_sync (accepts on wr_valid & wr_ready).
// Signals:
//   wr_valid  write request
//   wr_idx    target register index (IDX_W bits)
//   wr_data   write data (DW bits)
//   wr_ready  request is accepted on a cycle with wr_valid & wr_ready
interface frame_reg_sync_if #(
    parameter int DW    = 32,
    parameter int IDX_W = 4
);
    logic             wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic [DW-1:0]    wr_data;
    logic             wr_ready;

    modport master (output wr_valid, wr_idx, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_idx, wr_data, output wr_ready);
endinterface

// File: rtl/frame_reg_sync.sv
// frame_reg_sync
//   Double-buffered object-position registers between the game processor
//   and the RGB renderer (VGA_CLK domain). Writes land in a pending bank at
//   any time; dirty entries are copied to the display bank in one atomic
//   COMMIT cycle at the start of each vertical blank, so the renderer never
//   sees a half-updated frame.
// Ports:
//   clk_in        single clock (VGA_CLK)
//   reset         synchronous, active-high
//   Y             current scan line; Y >= V_ACTIVE is vertical blank
//   wr            frame_reg_sync_if.slave write port
//   disp_bus      display bank, register k at [k*DW +: DW]
//   commit_pulse  high for exactly the COMMIT cycle
//   frame_cnt     committed-frame counter (wraps)
//   err_idx       sticky: a write targeted an index >= NUM_REGS
//   game_tick     frame-rate pacing pulse
// Build option:
//   FRAME_TICK_EN  when defined, game_tick pulses on every TICK_DIV-th
//                  commit; otherwise game_tick is tied low and no divider
//                  exists.

// One register slot: pending value, dirty flag and displayed value.
module frame_reg_slot #(
    parameter int DW = 32
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    output logic [DW-1:0] display
);
    logic [DW-1:0] pending;
    logic          dirty;

    // wr_en is never asserted together with commit (wr_ready is low in
    // COMMIT), so the branch order carries no priority meaning.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pending <= '0;
            dirty   <= 1'b0;
            display <= '0;
        end else if (commit) begin
            if (dirty) display <= pending;
            dirty <= 1'b0;
        end else if (wr_en) begin
            pending <= wr_data;
            dirty   <= 1'b1;
        end
    end
endmodule

module frame_reg_sync #(
    parameter int NUM_REGS = 10,
    parameter int DW       = 32,
    parameter int V_ACTIVE = 1024,
    parameter int TICK_DIV = 4
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [31:0]            Y,
    frame_reg_sync_if.slave        wr,
    output logic [NUM_REGS*DW-1:0] disp_bus,
    output logic                   commit_pulse,
    output logic [15:0]            frame_cnt,
    output logic                   err_idx,
    output logic                   game_tick
);
    localparam int IDX_W = 4;
    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_COMMIT,
        ST_VBLANK
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [DW-1:0]    data;
    } wr_req_t;

    state_t  state, state_nxt;
    logic    vblank, vblank_q, rise;
    logic    wr_fire, idx_ok;
    wr_req_t req;

    // ---------------- blank detect ----------------
    assign vblank = (Y >= 32'(V_ACTIVE));
    assign rise   = vblank & ~vblank_q;

    // vblank_q resets high: a reset taken mid-blank must not look like a
    // fresh rise, so the first commit waits for the next real frame edge.
    always_ff @(posedge clk_in) begin
        if (reset) vblank_q <= 1'b1;
        else       vblank_q <= vblank;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (reset) state <= ST_ACTIVE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: begin
                if (rise)        state_nxt = ST_COMMIT;
                else if (vblank) state_nxt = ST_VBLANK;
            end
            ST_COMMIT: state_nxt = ST_VBLANK;
            ST_VBLANK: if (!vblank) state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_ACTIVE;
        endcase
    end

    assign commit_pulse = (state == ST_COMMIT);

    // ---------------- write port ----------------
    assign wr.wr_ready = (state != ST_COMMIT);
    assign req.idx     = wr.wr_idx;
    assign req.data    = wr.wr_data;
    assign wr_fire     = wr.wr_valid & wr.wr_ready;
    assign idx_ok      = ({1'b0, req.idx} < NREGS);

    always_ff @(posedge clk_in) begin
        if (reset)                  err_idx <= 1'b0;
        else if (wr_fire && !idx_ok) err_idx <= 1'b1;
    end

    // ---------------- register slots ----------------
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_slot
        logic slot_wr;
        assign slot_wr = wr_fire && (req.idx == IDX_W'(k));

        frame_reg_slot #(.DW(DW)) u_slot (
            .clk_in  (clk_in),
            .reset   (reset),
            .wr_en   (slot_wr),
            .wr_data (req.data),
            .commit  (commit_pulse),
            .display (disp_bus[k*DW +: DW])
        );
    end

    // ---------------- frame counter ----------------
    always_ff @(posedge clk_in) begin
        if (reset)             frame_cnt <= '0;
        else if (commit_pulse) frame_cnt <= frame_cnt + 16'd1;
    end

    // ---------------- game tick ----------------
`ifdef FRAME_TICK_EN
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    logic [7:0] tick_cnt;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            tick_cnt <= 8'd0;
        end else if (commit_pulse) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? 8'd0 : tick_cnt + 8'd1;
        end
    end

    assign game_tick = commit_pulse && (tick_cnt == TICK_LAST);
`else
    assign game_tick = 1'b0;
`endif
endmodule

// File: tb/tb_frame_reg_sync.sv
module tb_frame_reg_sync;
    localparam int NUM_REGS = 10;
    localparam int DW       = 32;
    localparam int V_ACTIVE = 1024;
    localparam int TICK_DIV = 4;
    localparam int CW       = NUM_REGS * DW;

    typedef logic [CW-1:0] cw_t;

    typedef struct {
        cw_t         disp;
        logic [15:0] fcnt;
        logic        tick;
        logic        err;
    } exp_t;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [31:0]       Y;
    logic [CW-1:0]     disp_bus;
    logic              commit_pulse;
    logic [15:0]       frame_cnt;
    logic              err_idx;
    logic              game_tick;

    frame_reg_sync_if #(.DW(DW), .IDX_W(4)) wif ();

    frame_reg_sync #(
        .NUM_REGS (NUM_REGS),
        .DW       (DW),
        .V_ACTIVE (V_ACTIVE),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .Y            (Y),
        .wr           (wif),
        .disp_bus     (disp_bus),
        .commit_pulse (commit_pulse),
        .frame_cnt    (frame_cnt),
        .err_idx      (err_idx),
        .game_tick    (game_tick)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input cw_t act, input cw_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: the latest value per index written since the last
    // commit; at each commit those replace the displayed values.
    logic [31:0] m_disp [NUM_REGS];
    logic [31:0] m_pend [int];
    logic        m_err;
    int          m_ncommit;
    exp_t        sb_q [$];

    task automatic model_reset();
        foreach (m_disp[k]) m_disp[k] = '0;
        m_pend.delete();
        m_err     = 1'b0;
        m_ncommit = 0;
        sb_q.delete();
    endtask

    task automatic model_commit();
        exp_t e;
        foreach (m_pend[k]) m_disp[k] = m_pend[k];
        m_pend.delete();
        m_ncommit++;
        e.disp = '0;
        for (int k = 0; k < NUM_REGS; k++) e.disp[k*DW +: DW] = m_disp[k];
        e.fcnt = 16'(m_ncommit);
`ifdef FRAME_TICK_EN
        e.tick = ((m_ncommit % TICK_DIV) == 0);
`else
        e.tick = 1'b0;
`endif
        e.err  = m_err;
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t cur;
    bit   cmp_pend = 1'b0;
    cw_t  last_disp = '0;

    always @(negedge clk_in) begin
        if (reset) begin
            cmp_pend  = 1'b0;
            last_disp = '0;
        end else begin
            if (cmp_pend) begin
                chk("commit_disp", disp_bus, cur.disp);
                chk("commit_frame_cnt", cw_t'(frame_cnt), cw_t'(cur.fcnt));
                chk("commit_err_idx", cw_t'(err_idx), cw_t'(cur.err));
                last_disp = cur.disp;
                cmp_pend  = 1'b0;
            end else begin
                chk("disp_hold", disp_bus, last_disp);
            end
            if (commit_pulse) begin
                chk("commit_expected", cw_t'(sb_q.size() != 0), cw_t'(1));
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    chk("game_tick", cw_t'(game_tick), cw_t'(cur.tick));
                    cmp_pend = 1'b1;
                end
            end else begin
                chk("game_tick_idle", cw_t'(game_tick), cw_t'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic step(input bit v, input logic [3:0] idx, input logic [31:0] d,
                        input logic [31:0] y, input bit exp_ready, input bit commits);
        Y            = y;
        wif.wr_valid = v;
        wif.wr_idx   = idx;
        wif.wr_data  = d;
        chk("wr_ready", cw_t'(wif.wr_ready), cw_t'(exp_ready));
        if (v && exp_ready) begin
            if (int'(idx) < NUM_REGS) m_pend[int'(idx)] = d;
            else                      m_err = 1'b1;
        end
        if (commits) model_commit();
        tick();
        wif.wr_valid = 1'b0;
        chk("err_idx", cw_t'(err_idx), cw_t'(m_err));
    endtask

    task automatic rand_wr(output bit v, output logic [3:0] i, output logic [31:0] d);
        v = ($urandom_range(0, 2) == 0);
        i = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15))
                                          : 4'($urandom_range(0, NUM_REGS - 1));
        d = $urandom;
    endtask

    function automatic logic [31:0] blank_y();
        return 32'(V_ACTIVE) + 32'($urandom_range(0, 100));
    endfunction

    // Rise cycle, COMMIT cycle (optionally holding a write across it), then
    // a couple of blank cycles.
    task automatic rise_commit(input bit hold, input logic [3:0] idx, input logic [31:0] d);
        step(1'b0, 4'd0, 32'd0, 32'(V_ACTIVE), 1'b1, 1'b1);
        step(hold, idx, d, blank_y(), 1'b0, 1'b0);
        if (hold) step(1'b1, idx, d, blank_y(), 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, blank_y(), 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, blank_y(), 1'b1, 1'b0);
    endtask

    task automatic rand_frame();
        bit v; logic [3:0] i; logic [31:0] d;
        bit hold;
        int n_act = $urandom_range(1, 6);
        int n_blk = $urandom_range(0, 5);
        for (int c = 0; c < n_act; c++) begin
            rand_wr(v, i, d);
            step(v, i, d, 32'($urandom_range(0, V_ACTIVE - 1)), 1'b1, 1'b0);
        end
        rand_wr(v, i, d);
        step(v, i, d, blank_y(), 1'b1, 1'b1);
        hold = ($urandom_range(0, 3) == 0);
        rand_wr(v, i, d);
        step(hold, i, d, blank_y(), 1'b0, 1'b0);
        if (hold) step(1'b1, i, d, blank_y(), 1'b1, 1'b0);
        for (int c = 0; c < n_blk; c++) begin
            rand_wr(v, i, d);
            step(v, i, d, blank_y(), 1'b1, 1'b0);
        end
    endtask

    task automatic do_reset(input logic [31:0] y);
        reset        = 1'b1;
        Y            = y;
        wif.wr_valid = 1'b0;
        wif.wr_idx   = '0;
        wif.wr_data  = '0;
        tick(); tick(); tick();
        model_reset();
        reset = 1'b0;
        chk("rst_disp_bus", disp_bus, cw_t'(0));
        chk("rst_frame_cnt", cw_t'(frame_cnt), cw_t'(0));
        chk("rst_err_idx", cw_t'(err_idx), cw_t'(0));
        chk("rst_commit_pulse", cw_t'(commit_pulse), cw_t'(0));
        chk("rst_game_tick", cw_t'(game_tick), cw_t'(0));
        chk("rst_wr_ready", cw_t'(wif.wr_ready), cw_t'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset(32'd0);

        // Full active sweep: no commit, nothing displayed.
        for (int y = 0; y < V_ACTIVE; y++) step(1'b0, 4'd0, 32'd0, 32'(y), 1'b1, 1'b0);
        chk("sweep_disp", disp_bus, cw_t'(0));
        chk("sweep_frame_cnt", cw_t'(frame_cnt), cw_t'(0));

        // Single write committed at the blank edge.
        step(1'b1, 4'd3, 32'h0000_0270, 32'd100, 1'b1, 1'b0);
        rise_commit(1'b0, 4'd0, 32'd0);
        chk("reg3_after_commit", cw_t'(disp_bus[3*DW +: DW]), cw_t'(32'h270));
        chk("frame_cnt_1", cw_t'(frame_cnt), cw_t'(1));

        // Last write wins; an empty frame keeps the value.
        step(1'b1, 4'd2, 32'hA, 32'd200, 1'b1, 1'b0);
        step(1'b1, 4'd2, 32'hB, 32'd201, 1'b1, 1'b0);
        rise_commit(1'b0, 4'd0, 32'd0);
        chk("reg2_last_wins", cw_t'(disp_bus[2*DW +: DW]), cw_t'(32'hB));
        step(1'b0, 4'd0, 32'd0, 32'd10, 1'b1, 1'b0);
        rise_commit(1'b0, 4'd0, 32'd0);
        chk("reg2_empty_frame", cw_t'(disp_bus[2*DW +: DW]), cw_t'(32'hB));
        chk("frame_cnt_3", cw_t'(frame_cnt), cw_t'(3));

        // Write held across the commit cycle lands in the next frame.
        step(1'b0, 4'd0, 32'd0, 32'd50, 1'b1, 1'b0);
        rise_commit(1'b1, 4'd0, 32'h55);
        chk("reg0_not_yet", cw_t'(disp_bus[0 +: DW]), cw_t'(0));
        step(1'b0, 4'd0, 32'd0, 32'd60, 1'b1, 1'b0);
        rise_commit(1'b0, 4'd0, 32'd0);
        chk("reg0_next_frame", cw_t'(disp_bus[0 +: DW]), cw_t'(32'h55));

        // Out-of-range index: sticky error, display untouched.
        step(1'b1, 4'd12, 32'hDEAD_BEEF, 32'd70, 1'b1, 1'b0);
        chk("err_idx_set", cw_t'(err_idx), cw_t'(1));
        rise_commit(1'b0, 4'd0, 32'd0);
        chk("err_idx_sticky", cw_t'(err_idx), cw_t'(1));

        // Randomized frames.
        for (int f = 0; f < 24; f++) rand_frame();

        // Reset taken mid-blank: no commit until the next real rise.
        do_reset(32'd1030);
        for (int c = 0; c < 4; c++) step(1'b0, 4'd0, 32'd0, 32'd1030, 1'b1, 1'b0);
        step(1'b1, 4'd5, 32'h1234_5678, 32'd1030, 1'b1, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd1000, 1'b1, 1'b0);
        rise_commit(1'b0, 4'd0, 32'd0);
        chk("post_reset_reg5", cw_t'(disp_bus[5*DW +: DW]), cw_t'(32'h1234_5678));
        chk("post_reset_frame_cnt", cw_t'(frame_cnt), cw_t'(1));

        // Eight frames from reset: tick cadence checked per commit.
        for (int f = 0; f < 8; f++) rand_frame();

        step(1'b0, 4'd0, 32'd0, 32'd5, 1'b1, 1'b0);
        tick();
        chk("scoreboard_drained", cw_t'(sb_q.size()), cw_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
